// File: rtl/wta_event_encoder_if.sv
// Port bundle for the winner-take-all event encoder: enable, six neuron
// potentials in, event/spike/winner status out.
interface wta_event_encoder_if #(
    parameter int p_width = 20
);
    logic               i_enable;
    logic [p_width-1:0] i_neuron_out_1;
    logic [p_width-1:0] i_neuron_out_2;
    logic [p_width-1:0] i_neuron_out_3;
    logic [p_width-1:0] i_neuron_out_4;
    logic [p_width-1:0] i_neuron_out_5;
    logic [p_width-1:0] i_neuron_out_6;
    logic [6:1]         o_event;
    logic               o_spike;
    logic [2:0]         o_winner;
    logic [p_width-1:0] o_winner_value;
    logic               o_busy;
    logic [15:0]        o_spike_count;

    modport slave (
        input  i_enable, i_neuron_out_1, i_neuron_out_2, i_neuron_out_3,
               i_neuron_out_4, i_neuron_out_5, i_neuron_out_6,
        output o_event, o_spike, o_winner, o_winner_value, o_busy, o_spike_count
    );

    modport master (
        output i_enable, i_neuron_out_1, i_neuron_out_2, i_neuron_out_3,
               i_neuron_out_4, i_neuron_out_5, i_neuron_out_6,
        input  o_event, o_spike, o_winner, o_winner_value, o_busy, o_spike_count
    );
endinterface

// File: rtl/wta_event_encoder.sv
// Winner-take-all event encoder: samples six neuron potentials, fires a
// one-cycle one-hot event for the strongest, then holds off for a refractory window.
module wta_event_encoder #(
    parameter int p_input_width  = 8,
    parameter int p_weight_width = 8,
    parameter int p_refractory   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    wta_event_encoder_if.slave io_bus
);
    localparam int W  = p_input_width + p_weight_width + 4;
    localparam int CW = (p_refractory > 1) ? $clog2(p_refractory) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (p_refractory > 0) ? CW'(p_refractory - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FIRE    = 2'd1,
        S_REFRACT = 2'd2
    } state_t;

    state_t            r_state, w_state_next;
    logic [5:0][W-1:0] w_in;
    logic [5:0][W-1:0] r_sample;
    logic              r_valid;
    logic [CW-1:0]     r_cnt;
    logic              w_any;
    logic [W-1:0]      w_max_val;
    logic [2:0]        w_max_idx;
    logic [6:1]        w_onehot;
    logic              w_capture;
    logic              w_enter_fire;
    logic              w_busy;

    logic [6:1]        r_event;
    logic              r_spike;
    logic [2:0]        r_winner;
    logic [W-1:0]      r_winner_value;
    logic [15:0]       r_spike_count;

    assign w_in = {io_bus.i_neuron_out_6, io_bus.i_neuron_out_5, io_bus.i_neuron_out_4,
                   io_bus.i_neuron_out_3, io_bus.i_neuron_out_2, io_bus.i_neuron_out_1};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (r_valid) w_state_next = S_FIRE;
            S_FIRE:    w_state_next = (p_refractory > 0) ? S_REFRACT : S_IDLE;
            S_REFRACT: if (r_cnt == '0) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Sampling is keyed off the state we are entering, so the edge that ends
    // the refractory window is already a capture edge (spike spacing p+2).
    always_comb begin
        w_enter_fire = (r_state == S_IDLE) && r_valid;
        w_capture    = io_bus.i_enable && (w_state_next == S_IDLE);
        w_busy       = (r_state != S_IDLE);
    end

    always_comb begin
        w_any = 1'b0;
        for (int k = 0; k < 6; k++) w_any = w_any | (w_in[k] != '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_capture) begin
                r_sample <= w_in;
                r_valid  <= w_any;
            end
        end
    end

    // Strict greater-than while scanning upward keeps ties on the lowest index.
    always_comb begin
        w_max_val = r_sample[0];
        w_max_idx = 3'd1;
        for (int k = 1; k < 6; k++) begin
            if (r_sample[k] > w_max_val) begin
                w_max_val = r_sample[k];
                w_max_idx = 3'(k + 1);
            end
        end
        w_onehot = '0;
        for (int k = 1; k <= 6; k++) w_onehot[k] = (w_max_idx == 3'(k));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                   r_cnt <= '0;
        else if (r_state == S_FIRE)                  r_cnt <= CNT_LOAD;
        else if (r_state == S_REFRACT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_event        <= '0;
            r_spike        <= 1'b0;
            r_winner       <= '0;
            r_winner_value <= '0;
            r_spike_count  <= '0;
        end else begin
            r_event <= w_enter_fire ? w_onehot : '0;
            r_spike <= w_enter_fire;
            if (w_enter_fire) begin
                r_winner       <= w_max_idx;
                r_winner_value <= w_max_val;
                if (r_spike_count != 16'hFFFF) r_spike_count <= r_spike_count + 1'b1;
            end
        end
    end

    assign io_bus.o_event        = r_event;
    assign io_bus.o_spike        = r_spike;
    assign io_bus.o_winner       = r_winner;
    assign io_bus.o_winner_value = r_winner_value;
    assign io_bus.o_busy         = w_busy;
    assign io_bus.o_spike_count  = r_spike_count;
endmodule

// File: tb/tb_wta_event_encoder.sv
// Bench for wta_event_encoder: directed steps plus random traffic, every cycle
// compared against a timeline model of fire / refractory / capture behaviour.
module tb_wta_event_encoder;
    localparam int W = 20;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic [W-1:0] din [1:6];

    int n_assert = 0;
    int n_fail   = 0;

    wta_event_encoder_if #(.p_width(W)) bus ();

    assign bus.i_enable       = en;
    assign bus.i_neuron_out_1 = din[1];
    assign bus.i_neuron_out_2 = din[2];
    assign bus.i_neuron_out_3 = din[3];
    assign bus.i_neuron_out_4 = din[4];
    assign bus.i_neuron_out_5 = din[5];
    assign bus.i_neuron_out_6 = din[6];

    wta_event_encoder #(.p_input_width(8), .p_weight_width(8), .p_refractory(P)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    always #5 clk = ~clk;

    // Model: a capture with a nonzero candidate fires on the next edge, a fire
    // keeps the block busy for P+1 cycles, and the edge ending that window captures.
    int           m_busy_left;
    bit           m_fire_next;
    int           m_cand;
    logic [W-1:0] m_cand_val;
    logic [6:1]   m_event;
    bit           m_spike;
    int           m_winner;
    logic [W-1:0] m_wval;
    int           m_count;

    task automatic model_reset();
        m_busy_left = 0; m_fire_next = 0; m_cand = 0; m_cand_val = '0;
        m_event = '0; m_spike = 0; m_winner = 0; m_wval = '0; m_count = 0;
    endtask

    task automatic model_edge();
        int           best;
        logic [W-1:0] val;
        if (rst) begin model_reset(); return; end
        m_event = '0;
        m_spike = 0;
        if (m_fire_next) begin
            m_fire_next = 0;
            m_winner = m_cand;
            m_wval = m_cand_val;
            m_event[m_cand] = 1'b1;
            m_spike = 1;
            if (m_count < 65535) m_count++;
            m_busy_left = P + 1;
        end else begin
            if (m_busy_left > 0) m_busy_left--;
            if (m_busy_left == 0 && en) begin
                best = 0; val = '0;
                for (int k = 1; k <= 6; k++)
                    if (din[k] > val) begin val = din[k]; best = k; end
                if (best != 0) begin m_fire_next = 1; m_cand = best; m_cand_val = val; end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("event",  32'(bus.o_event),        32'(m_event));
        chk("spike",  32'(bus.o_spike),        32'(m_spike));
        chk("winner", 32'(bus.o_winner),       32'(m_winner));
        chk("wvalue", 32'(bus.o_winner_value), 32'(m_wval));
        chk("busy",   32'(bus.o_busy),         32'(m_busy_left > 0));
        chk("count",  32'(bus.o_spike_count),  32'(m_count));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic zero_inputs();
        for (int k = 1; k <= 6; k++) din[k] = '0;
    endtask

    task automatic wait_spike(input string tag);
        bit ok = 0;
        for (int i = 0; i < 12 && !ok; i++) begin
            step();
            if (bus.o_spike) ok = 1;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return ($urandom_range(0, 1) != 0) ? 20'h00020 : 20'h00010;
            2:       return W'($urandom);
            default: return 20'hFFFFF;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last, busy_cnt, nsp, cnt_before, sp_seen;
        model_reset();

        // Reset held with random inputs: everything stays zero.
        for (int k = 1; k <= 6; k++) din[k] = rnd_val() | 20'h1;
        for (int i = 0; i < 3; i++) step();
        zero_inputs();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Single winner on input 3.
        din[3] = 20'h00150;
        step();
        zero_inputs();
        step();
        chk("single_event",  32'(bus.o_event),        32'h04);
        chk("single_winner", 32'(bus.o_winner),       32'd3);
        chk("single_value",  32'(bus.o_winner_value), 32'h00150);
        chk("single_count",  32'(bus.o_spike_count),  32'd1);
        step();
        chk("single_pulse_end", 32'(bus.o_event), 32'h0);
        for (int i = 0; i < 6; i++) step();

        // Tie between inputs 2 and 5 goes to the lower index.
        din[2] = 20'h00400; din[5] = 20'h00400; din[6] = 20'h003FF;
        step();
        zero_inputs();
        step();
        chk("tie_winner", 32'(bus.o_winner), 32'd2);
        for (int i = 0; i < 6; i++) step();
        din[2] = 20'h00400; din[5] = 20'h00401; din[6] = 20'h003FF;
        step();
        zero_inputs();
        step();
        chk("max_winner", 32'(bus.o_winner), 32'd5);
        chk("max_value",  32'(bus.o_winner_value), 32'h00401);
        for (int i = 0; i < 6; i++) step();

        // Refractory: constant input 1, a large input 4 pulse during REFRACT.
        din[1] = 20'h00010;
        last = -1; busy_cnt = 0; nsp = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            step();
            if (bus.o_spike) begin
                if (last >= 0) begin
                    chk("refr_spacing", 32'(cyc - last), 32'd6);
                    chk("refr_busy",    32'(busy_cnt),   32'd5);
                end
                busy_cnt = 0; last = cyc; nsp++;
            end
            if (bus.o_busy) busy_cnt++;
            if (last >= 0 && cyc == last + 2) din[4] = 20'hFFFFF;
            if (last >= 0 && cyc == last + 3) din[4] = '0;
        end
        chk("refr_spikes", 32'(nsp), 32'd4);
        chk("refr_winner", 32'(bus.o_winner), 32'd1);
        zero_inputs();
        for (int i = 0; i < 6; i++) step();

        // Enable low: nonzero inputs never fire.
        en = 1'b0;
        cnt_before = int'(bus.o_spike_count);
        sp_seen = 0;
        for (int i = 0; i < 10; i++) begin
            for (int k = 1; k <= 6; k++) din[k] = rnd_val() | 20'h1;
            step();
            if (bus.o_spike) sp_seen++;
        end
        chk("en_off_spikes", 32'(sp_seen), 32'd0);
        chk("en_off_count",  32'(bus.o_spike_count), 32'(cnt_before));

        // Enable dropped during REFRACT: sequence completes, nothing more fires.
        en = 1'b1; zero_inputs(); din[1] = 20'h00010;
        wait_spike("en_drop_fire");
        en = 1'b0;
        sp_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.o_spike) sp_seen++;
        end
        chk("en_drop_spikes", 32'(sp_seen), 32'd0);
        chk("en_drop_busy",   32'(bus.o_busy), 32'd0);

        // Reset mid-FIRE truncates the pulse immediately.
        en = 1'b1;
        wait_spike("rst_fire");
        rst = 1'b1;
        #1;
        chk("rst_event",  32'(bus.o_event),       32'h0);
        chk("rst_spike",  32'(bus.o_spike),       32'd0);
        chk("rst_busy",   32'(bus.o_busy),        32'd0);
        chk("rst_count",  32'(bus.o_spike_count), 32'd0);
        model_reset();
        step(); step();
        rst = 1'b0;

        // Random traffic with sparse inputs, ties and enable toggling.
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 7) != 0);
            for (int k = 1; k <= 6; k++) din[k] = rnd_val();
            step();
        end

        // Counter saturation from a preloaded value.
        en = 1'b1; zero_inputs();
        for (int i = 0; i < 8; i++) step();
        force dut.r_spike_count = 16'hFFFE;
        #1;
        release dut.r_spike_count;
        m_count = 65534;
        din[1] = 20'h00010;
        for (int i = 0; i < 16; i++) step();
        chk("sat_count", 32'(bus.o_spike_count), 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
